// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory stage of the pipeline plus the M/W pipeline register.
//
// Issues load/store requests on a simple request/ready data-memory port,
// stalls upstream while the memory is not ready, aligns store data and byte
// enables, extracts and extends load data, and registers everything that the
// write-back stage consumes.
//
// Handshake: dmem_req/dmem_ready are a valid/ready pair. A request is
// presented with dmem_req=1 and the access completes on the first rising
// edge where dmem_req=1 and dmem_ready=1. Once presented, the request and its
// address/data/byte enables stay stable until that completing edge, or until
// the wait-cycle budget expires and the access is abandoned.
//
// Parameters
//   WAIT_MAX    maximum number of WAIT cycles before a bus-error abort (>= 1)
//
// Configuration macro
//   MEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are not
//                         issued and retire as bus errors; when undefined the
//                         offending low address bits are ignored.
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   ValidM, RegWriteM, jumpM           M-stage valid, reg write, jal flag
//   MemWriteM[1:0]                     result select (11 load, 10 ALU, 0x PC+8)
//   StoreM, SizeM[1:0], SignedM        store request, access size, load sign
//   WriteRegM, ALUOutM, WriteDataM,    destination, address/ALU result,
//   PCPlus8M                           store data, link value
//   dmem_req, dmem_we, dmem_addr,      data-memory request side
//   dmem_wdata, dmem_be
//   dmem_rdata, dmem_ready             data-memory response side
//   StallM                             holds the upstream stages
//   RegWriteW, jumpW, MemWriteW,       registered write-back outputs
//   WriteRegW, ReadDataW, ALUOutW,
//   PCPlus8W, BusErrW
//   dbg_state                          1 while the FSM is in WAIT
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ValidM,
   input  logic        RegWriteM,
   input  logic        jumpM,
   input  logic [1:0]  MemWriteM,
   input  logic        StoreM,
   input  logic [1:0]  SizeM,
   input  logic        SignedM,
   input  logic [4:0]  WriteRegM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCPlus8M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        StallM,
   output logic        RegWriteW,
   output logic        jumpW,
   output logic [1:0]  MemWriteW,
   output logic [4:0]  WriteRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [31:0] PCPlus8W,
   output logic        BusErrW,
   output logic        dbg_state
);

   localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   // Everything about one M-stage instruction that the access and the
   // write-back need. Captured on entry to WAIT so the bus and the eventual
   // W load do not depend on upstream keeping its outputs steady.
   typedef struct packed {
      logic        store;
      logic [1:0]  size;
      logic        sgn;
      logic        reg_write;
      logic        jump;
      logic [1:0]  mem_write;
      logic [4:0]  write_reg;
      logic [31:0] alu_out;
      logic [31:0] write_data;
      logic [31:0] pc_plus8;
   } acc_t;

   // ---------------------------------------------------------------------------
   // Lane helpers
   // ---------------------------------------------------------------------------
   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;   // half lane chosen by addr[1]
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] d;
      case (size)
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = lane[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   acc_t            cap_q, cap_d;

   logic            reg_write_w_q, reg_write_w_d;
   logic            jump_w_q, jump_w_d;
   logic [1:0]      mem_write_w_q, mem_write_w_d;
   logic [4:0]      write_reg_w_q, write_reg_w_d;
   logic [31:0]     read_data_w_q, read_data_w_d;
   logic [31:0]     alu_out_w_q, alu_out_w_d;
   logic [31:0]     pc_plus8_w_q, pc_plus8_w_d;
   logic            bus_err_w_q, bus_err_w_d;

   // ---------------------------------------------------------------------------
   // Access decode
   // ---------------------------------------------------------------------------
   acc_t  m_acc;
   acc_t  cur;
   logic  in_wait;
   logic  mem_op_m;
   logic  misalign_m;
   logic  access_m;
   logic  timeout;
   logic  w_err;
   logic  is_load;
   logic  [31:0] load_data;

   assign in_wait  = (state_q == S_WAIT);
   assign mem_op_m = ValidM & (StoreM | (MemWriteM == 2'b11));

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_m = mem_op_m & (((SizeM == 2'b01) & ALUOutM[0]) |
                                   (SizeM[1] & (ALUOutM[1:0] != 2'b00)));
`else
   assign misalign_m = 1'b0;
`endif

   assign access_m = mem_op_m & ~misalign_m;

   always_comb begin
      m_acc            = '0;
      m_acc.store      = StoreM;
      m_acc.size       = SizeM;
      m_acc.sgn        = SignedM;
      m_acc.reg_write  = RegWriteM;
      m_acc.jump       = jumpM;
      m_acc.mem_write  = MemWriteM;
      m_acc.write_reg  = WriteRegM;
      m_acc.alu_out    = ALUOutM;
      m_acc.write_data = WriteDataM;
      m_acc.pc_plus8   = PCPlus8M;
   end

   // In WAIT the captured copy drives the bus so it cannot move mid-access.
   assign cur = in_wait ? cap_q : m_acc;

   // Budget expires on the last permitted WAIT cycle if memory is still busy.
   assign timeout = in_wait & ~dmem_ready & (cnt_q == CW'(WAIT_MAX - 1));

   // Request and stall are gated by reset_n so they drop the instant reset
   // is asserted, not at the next edge.
   assign dmem_req   = reset_n & (in_wait | access_m);
   assign dmem_we    = cur.store;
   assign dmem_addr  = {cur.alu_out[31:2], 2'b00};
   assign dmem_be    = store_be(cur.size, cur.alu_out[1:0]);
   assign dmem_wdata = store_data(cur.size, cur.write_data);
   assign StallM     = dmem_req & ~dmem_ready & ~timeout;

   assign load_data  = load_extend(dmem_rdata, cur.alu_out[1:0], cur.size, cur.sgn);
   assign w_err      = timeout | (~in_wait & misalign_m);
   assign is_load    = in_wait ? ~cap_q.store : (access_m & ~StoreM);

   // ---------------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      case (state_q)
         S_IDLE: begin
            if (access_m & ~dmem_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               cap_d   = m_acc;
            end
         end
         S_WAIT: begin
            if (dmem_ready | timeout) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // M/W register next value. While stalled a bubble is loaded so the
   // write-back stage never sees the same instruction twice. ReadDataW
   // carries data only for a load that actually completed; it is zero
   // otherwise, so a stale value never looks like fresh load data.
   // ---------------------------------------------------------------------------
   always_comb begin
      reg_write_w_d = 1'b0;
      jump_w_d      = 1'b0;
      mem_write_w_d = 2'b00;
      write_reg_w_d = 5'd0;
      read_data_w_d = 32'd0;
      alu_out_w_d   = 32'd0;
      pc_plus8_w_d  = 32'd0;
      bus_err_w_d   = 1'b0;
      if (~StallM & (in_wait | ValidM)) begin
         reg_write_w_d = cur.reg_write & ~cur.store & ~w_err;
         jump_w_d      = cur.jump;
         mem_write_w_d = cur.mem_write;
         write_reg_w_d = cur.write_reg;
         read_data_w_d = (is_load & ~w_err) ? load_data : 32'd0;
         alu_out_w_d   = cur.alu_out;
         pc_plus8_w_d  = cur.pc_plus8;
         bus_err_w_d   = w_err;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         cap_q         <= '0;
         reg_write_w_q <= 1'b0;
         jump_w_q      <= 1'b0;
         mem_write_w_q <= 2'b00;
         write_reg_w_q <= 5'd0;
         read_data_w_q <= 32'd0;
         alu_out_w_q   <= 32'd0;
         pc_plus8_w_q  <= 32'd0;
         bus_err_w_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cap_q         <= cap_d;
         reg_write_w_q <= reg_write_w_d;
         jump_w_q      <= jump_w_d;
         mem_write_w_q <= mem_write_w_d;
         write_reg_w_q <= write_reg_w_d;
         read_data_w_q <= read_data_w_d;
         alu_out_w_q   <= alu_out_w_d;
         pc_plus8_w_q  <= pc_plus8_w_d;
         bus_err_w_q   <= bus_err_w_d;
      end
   end

   assign RegWriteW = reg_write_w_q;
   assign jumpW     = jump_w_q;
   assign MemWriteW = mem_write_w_q;
   assign WriteRegW = write_reg_w_q;
   assign ReadDataW = read_data_w_q;
   assign ALUOutW   = alu_out_w_q;
   assign PCPlus8W  = pc_plus8_w_q;
   assign BusErrW   = bus_err_w_q;
   assign dbg_state = in_wait;

endmodule
